// File: rtl/branch_resolve.sv
// Execute-stage branch resolver: decides taken/target for the EX instruction and
// drives the registered redirect strobe, PC-relative offset and flush to fetch.
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [4:0]       ex_opcode,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_opA,
  input  logic [31:0]      ex_opB,
  input  logic [31:0]      fetch_pc,
  input  logic             stall,
  output logic             branchtaken,
  output logic [31:0]      branchimmediate,
  output logic             flush,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_BLT = 5'b00110;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } state_t;

  state_t           state_q;
  logic [2:0]       cnt_q;
  logic             branchtaken_q;
  logic [31:0]      branchimmediate_q;
  logic             flush_q;
  logic [CNT_W-1:0] taken_count_q;

  logic             taken_d;
  logic [31:0]      target_d;
  logic [31:0]      offset_d;
  logic             accept_d;
  logic signed [31:0] opa_s;
  logic signed [31:0] opb_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign opa_s = ex_opA;
  assign opb_s = ex_opB;

  always_comb begin
    taken_d  = 1'b0;
    target_d = ex_pc + 32'd1 + ex_imm;
    unique case (ex_opcode)
      OP_J, OP_JAL: begin
        taken_d  = 1'b1;
        target_d = {5'b0, ex_imm[26:0]};
      end
      OP_JR: begin
        taken_d  = 1'b1;
        target_d = ex_opB;
      end
      OP_BNE: taken_d = (ex_opA != ex_opB);
      OP_BLT: taken_d = (opa_s < opb_s);
      default: taken_d = 1'b0;
    endcase
  end

  // Fetch will already have stepped to fetch_pc+1 when the strobe lands.
  assign offset_d = target_d - (fetch_pc + 32'd1);
  assign accept_d = ex_valid & taken_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      cnt_q             <= 3'd0;
      branchtaken_q     <= 1'b0;
      branchimmediate_q <= 32'd0;
      flush_q           <= 1'b0;
      taken_count_q     <= '0;
    end else if (!stall) begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            state_q           <= REDIRECT;
            branchtaken_q     <= 1'b1;
            branchimmediate_q <= offset_d;
            flush_q           <= 1'b1;
            cnt_q             <= CNT_INIT;
            taken_count_q     <= sat_inc(taken_count_q);
          end else begin
            branchtaken_q <= 1'b0;
          end
        end
        REDIRECT: begin
          branchtaken_q <= 1'b0;
          if (cnt_q == 3'd0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else begin
            state_q <= FLUSH;
            cnt_q   <= cnt_q - 3'd1;
          end
        end
        // Wrong-path shadow: EX contents are ignored until the count drains.
        FLUSH: begin
          if (cnt_q == 3'd0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q       <= IDLE;
          branchtaken_q <= 1'b0;
          flush_q       <= 1'b0;
        end
      endcase
    end
  end

  assign branchtaken     = branchtaken_q;
  assign branchimmediate = branchimmediate_q;
  assign flush           = flush_q;
  assign taken_count     = taken_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Randomized bench for branch_resolve against a cycle-level behavioural model,
// plus directed cases for offsets, shadowing, stall hold, async reset and saturation.
module tb_branch_resolve;
  localparam int FC = 2;

  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_JAL = 5'b00011;
  localparam logic [4:0] OP_JR  = 5'b00100;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_BLT = 5'b00110;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_opcode;
  logic [31:0] ex_pc, ex_imm, ex_opA, ex_opB, fetch_pc;
  logic        stall;

  logic        bt, fl, bt2, fl2;
  logic [31:0] bimm, bimm2;
  logic [15:0] tc;
  logic [1:0]  tc2;

  int total = 0;
  int bad   = 0;

  // Model state: flush cycles remaining, strobe, offset, number of redirects.
  int          rem;
  bit          m_bt;
  logic [31:0] m_imm;
  int          m_cnt;

  branch_resolve #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_opA(ex_opA), .ex_opB(ex_opB), .fetch_pc(fetch_pc), .stall(stall),
    .branchtaken(bt), .branchimmediate(bimm), .flush(fl), .taken_count(tc)
  );

  branch_resolve #(.FLUSH_CYCLES(FC), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_opA(ex_opA), .ex_opB(ex_opB), .fetch_pc(fetch_pc), .stall(stall),
    .branchtaken(bt2), .branchimmediate(bimm2), .flush(fl2), .taken_count(tc2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic ref_resolve(input logic [4:0] op, input logic [31:0] pc, input logic [31:0] imm,
                             input logic [31:0] a, input logic [31:0] b,
                             output bit tk, output logic [31:0] tgt);
    tk  = 1'b0;
    tgt = pc + 32'd1 + imm;
    if (op == OP_J || op == OP_JAL) begin
      tk  = 1'b1;
      tgt = {5'b0, imm[26:0]};
    end else if (op == OP_JR) begin
      tk  = 1'b1;
      tgt = b;
    end else if (op == OP_BNE) begin
      tk = (a != b);
    end else if (op == OP_BLT) begin
      tk = ($signed(a) < $signed(b));
    end
  endtask

  task automatic model_reset();
    rem   = 0;
    m_bt  = 1'b0;
    m_imm = 32'd0;
    m_cnt = 0;
  endtask

  task automatic drive(input bit v, input logic [4:0] op, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] fpc, input bit st);
    ex_valid  = v;
    ex_opcode = op;
    ex_pc     = pc;
    ex_imm    = imm;
    ex_opA    = a;
    ex_opB    = b;
    fetch_pc  = fpc;
    stall     = st;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic step();
    bit          tk;
    logic [31:0] tgt;
    @(posedge clk);
    if (!stall) begin
      if (rem > 0) begin
        rem--;
        m_bt = 1'b0;
      end else begin
        ref_resolve(ex_opcode, ex_pc, ex_imm, ex_opA, ex_opB, tk, tgt);
        if (ex_valid && tk) begin
          m_bt  = 1'b1;
          m_imm = tgt - (fetch_pc + 32'd1);
          rem   = FC;
          m_cnt++;
        end else begin
          m_bt = 1'b0;
        end
      end
    end
    #1;
    chk("bt", bt, m_bt);
    chk("imm", bimm, m_imm);
    chk("flush", fl, rem > 0);
    chk("cnt", tc, sat(m_cnt, 65535));
    chk("cnt_sat", tc2, sat(m_cnt, 3));
    chk("dup_ctl", {bt2, fl2}, {m_bt, rem > 0});
    chk("dup_imm", bimm2, m_imm);
  endtask

  logic [4:0] ops [8] = '{OP_J, OP_JAL, OP_JR, OP_BNE, OP_BLT, OP_BLT, 5'b00000, 5'b11111};

  initial begin
    int highs;
    int c0;
    rst = 1'b1;
    idle();
    model_reset();
    #12;
    chk("rst_bt", bt, 0);
    chk("rst_imm", bimm, 0);
    chk("rst_flush", fl, 0);
    chk("rst_cnt", tc, 0);
    rst = 1'b0;
    step();

    // bne taken: target 16, fetch holds 13 -> offset 3, flush for two cycles
    drive(1'b1, OP_BNE, 32'd10, 32'd5, 32'd3, 32'd4, 32'd12, 1'b0);
    step();
    chk("t2_bt", bt, 1);
    chk("t2_imm", bimm, 32'd3);
    chk("t2_flush", fl, 1);
    chk("t2_cnt", tc, 1);
    idle();
    step();
    chk("t2_flush2", fl, 1);
    chk("t2_bt_off", bt, 0);
    step();
    chk("t2_flush_off", fl, 0);

    // blt signed: -1 < 1 taken, 1 < -1 not taken
    drive(1'b1, OP_BLT, 32'd100, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd1, 32'd101, 1'b0);
    step();
    chk("t3_bt", bt, 1);
    chk("t3_imm", bimm, 32'hFFFF_FFFB);
    idle();
    step();
    step();
    drive(1'b1, OP_BLT, 32'd100, 32'd4, 32'd1, 32'hFFFF_FFFF, 32'd101, 1'b0);
    step();
    chk("t3_nt_bt", bt, 0);
    chk("t3_nt_flush", fl, 0);

    // jr with wrapping offset
    drive(1'b1, OP_JR, 32'd7, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
    step();
    chk("t4_bt", bt, 1);
    chk("t4_imm", bimm, 32'd0);
    idle();
    step();
    step();

    // j, then jal in the shadow with a 3-cycle stall on the strobe
    drive(1'b1, OP_J, 32'd5, 32'h0000_0040, 32'd0, 32'd0, 32'h10, 1'b0);
    step();
    highs = bt ? 1 : 0;
    c0 = tc;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, OP_JAL, 32'd6, 32'h0000_0080, 32'd0, 32'd0, 32'h11, 1'b1);
      step();
      if (bt) highs++;
    end
    drive(1'b1, OP_JAL, 32'd6, 32'h0000_0080, 32'd0, 32'd0, 32'h11, 1'b0);
    step();
    if (bt) highs++;
    step();
    if (bt) highs++;
    chk("t5_hold", highs, 4);
    chk("t5_cnt", tc, c0);
    chk("t5_flush_off", fl, 0);
    idle();
    step();

    // async reset in the middle of the flush window
    drive(1'b1, OP_J, 32'd0, 32'h0000_0123, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    idle();
    step();
    chk("t1_pre_flush", fl, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t1_bt", bt, 0);
    chk("t1_imm", bimm, 0);
    chk("t1_flush", fl, 0);
    chk("t1_cnt", tc, 0);
    rst = 1'b0;
    model_reset();
    step();

    // five jumps saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, OP_J, 32'd0, 32'(i * 8), 32'd0, 32'd0, 32'(i), 1'b0);
      step();
      idle();
      step();
      step();
    end
    chk("t6_sat", tc2, 3);
    chk("t6_cnt", tc, 5);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) - 32'd4 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a :
          (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) - 32'd4 : $urandom);
      drive($urandom_range(0, 9) < 7, ($urandom_range(0, 7) == 7) ? 5'($urandom) : ops[$urandom_range(0, 7)],
            $urandom, $urandom, a, b, $urandom, $urandom_range(0, 4) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
